// File: rtl/jclk_pkg.sv
// Shared types and constants for the jclk_stepper CPU clock/step generator.
// Holds the run-state enum, phase encodings and the per-phase clock table.
package jclk_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } jclk_state_e;

   localparam logic [1:0] PH0 = 2'd0;
   localparam logic [1:0] PH1 = 2'd1;
   localparam logic [1:0] PH2 = 2'd2;
   localparam logic [1:0] PH3 = 2'd3;

   localparam int NSTEPS_DEF = 6;

   // Clock bundle per phase, packed as {clk, clkd, clke, clks}.
   function automatic logic [3:0] phase_clocks(input logic [1:0] ph);
      logic [3:0] r;
      case (ph)
         PH0:     r = 4'b1010;
         PH1:     r = 4'b1111;
         PH2:     r = 4'b0110;
         default: r = 4'b0000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/jclk_stepper_ring.sv
// One-hot step ring: clr empties it, load0 selects step 0, adv rotates one step.
// Priority is clr, then load0, then adv.
module jring_stepper #(
   parameter int NSTEPS = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              load0,
   input  logic              adv,
   output logic [0:NSTEPS-1] stp_q
);

   logic [0:NSTEPS-1] stp_d;

   always_comb begin
      stp_d = stp_q;
      if (clr) begin
         stp_d = '0;
      end else if (load0) begin
         stp_d    = '0;
         stp_d[0] = 1'b1;
      end else if (adv) begin
         stp_d = {stp_q[NSTEPS-1], stp_q[0:NSTEPS-2]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stp_q <= '0;
      end else begin
         stp_q <= stp_d;
      end
   end

endmodule

// File: rtl/jclk_stepper.sv
// CPU clock-phase and step-bus generator with run/halt sequencing and an instruction counter.
// Optional single-step mode is enabled with the JCLK_SINGLE_STEP_EN macro.
module jclk_stepper
   import jclk_pkg::*;
#(
   parameter int NSTEPS = NSTEPS_DEF,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic              halt,
`ifdef JCLK_SINGLE_STEP_EN
   input  logic              step_req,
   input  logic              single,
`endif
   output logic              CLK_clk,
   output logic              CLK_clkd,
   output logic              CLK_clke,
   output logic              CLK_clks,
   output logic [0:NSTEPS-1] STP_bus,
   output logic              running,
   output logic [CNT_W-1:0]  instr_cnt
);

   jclk_state_e      state_q, state_d;
   logic [1:0]       phase_q, phase_d;
   logic             halt_pend_q, halt_pend_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       clks_q, clks_d;
   logic             running_q, running_d;

   logic ring_clr, ring_load0, ring_adv;
   logic start_req, single_stop;

`ifdef JCLK_SINGLE_STEP_EN
   logic step_req_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_req_q <= 1'b0;
      end else begin
         step_req_q <= step_req;
      end
   end

   // Only a fresh rising edge of step_req may restart a halted machine.
   assign start_req   = run | (step_req & ~step_req_q);
   assign single_stop = single;
`else
   assign start_req   = run;
   assign single_stop = 1'b0;
`endif

   jring_stepper #(
      .NSTEPS (NSTEPS)
   ) u_ring (
      .clk   (clk),
      .reset (reset),
      .clr   (ring_clr),
      .load0 (ring_load0),
      .adv   (ring_adv),
      .stp_q (STP_bus)
   );

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      halt_pend_d = halt_pend_q;
      cnt_d       = cnt_q;
      ring_clr    = 1'b0;
      ring_load0  = 1'b0;
      ring_adv    = 1'b0;

      case (state_q)
         IDLE: begin
            if (run) begin
               state_d    = RUN;
               phase_d    = PH0;
               ring_load0 = 1'b1;
            end
         end
         HALTED: begin
            if (start_req) begin
               state_d    = RUN;
               phase_d    = PH0;
               ring_load0 = 1'b1;
            end
         end
         RUN: begin
            phase_d = phase_q + 2'd1;
            if (halt) begin
               halt_pend_d = 1'b1;
            end
            // The last phase of the last step closes the instruction; a halt seen in that very cycle still counts.
            if (phase_q == PH3) begin
               if (STP_bus[NSTEPS-1]) begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (halt_pend_q || halt || single_stop) begin
                     state_d     = HALTED;
                     halt_pend_d = 1'b0;
                     ring_clr    = 1'b1;
                  end else begin
                     ring_adv = 1'b1;
                  end
               end else begin
                  ring_adv = 1'b1;
               end
            end
         end
         default: begin
            state_d  = IDLE;
            ring_clr = 1'b1;
         end
      endcase

      clks_d    = (state_d == RUN) ? phase_clocks(phase_d) : 4'b0000;
      running_d = (state_d == RUN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         phase_q     <= PH0;
         halt_pend_q <= 1'b0;
         cnt_q       <= '0;
         clks_q      <= 4'b0000;
         running_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         halt_pend_q <= halt_pend_d;
         cnt_q       <= cnt_d;
         clks_q      <= clks_d;
         running_q   <= running_d;
      end
   end

   assign CLK_clk   = clks_q[3];
   assign CLK_clkd  = clks_q[2];
   assign CLK_clke  = clks_q[1];
   assign CLK_clks  = clks_q[0];
   assign running   = running_q;
   assign instr_cnt = cnt_q;

endmodule

// File: doc/jclk_stepper.md
Name: jclk_stepper

Overview:
- Generates the CPU clock phases (CLK_clk, CLK_clkd, CLK_clke, CLK_clks) and the one-hot step bus (STP_bus) from a single master clock.
- These signals drive the control unit, which ANDs them with decoded instruction bits.
- Sits directly upstream of the control unit and consumes its halt output.
- Adds run/halt sequencing: halt always lets the current instruction finish; an instruction counter is provided.

Parameters:
- NSTEPS, 6, number of steps per instruction; width of STP_bus.
- CNT_W, 16, width of the completed-instruction counter.

Ports:
- clk  in  1  master clock; every transition happens on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- run  in  1  start/resume request; level sampled each clk.
- halt  in  1  halt request from the control unit; level sampled each clk.
- CLK_clk  out  1  CPU clock.
- CLK_clkd  out  1  CPU clock delayed by one quarter period.
- CLK_clke  out  1  enable window, equal to CLK_clk OR CLK_clkd.
- CLK_clks  out  1  set window, equal to CLK_clk AND CLK_clkd.
- STP_bus  out  [0:NSTEPS-1]  one-hot current step, or all zero when not running.
- running  out  1  high while in RUN.
- instr_cnt  out  CNT_W  count of completed instructions.

Behaviour:
- Interface decision: one clock, clk; reset is asynchronous and active-high, port name reset.
- All outputs are registered; no combinational paths from inputs to outputs.
- Reset:
  - Immediately forces state IDLE, phase 0, step 0 and halt_pend 0.
  - All outputs go to 0: STP_bus all zero, instr_cnt 0, running 0.
  - Applies mid-operation too, with no completion of the instruction in progress.
- State IDLE:
  - All outputs 0 except instr_cnt.
  - At the edge sampling run=1: enter RUN with phase 0 and STP_bus[0]=1 at that same edge.
  - halt is ignored.
- State RUN:
  - A 2-bit phase counter advances 0,1,2,3,0 every clk.
  - Clock outputs per phase (clk, clkd, clke, clks): phase 0 = 1,0,1,0; phase 1 = 1,1,1,1; phase 2 = 0,1,1,0; phase 3 = 0,0,0,0.
  - Each step lasts exactly 4 clk cycles.
  - On the 3->0 phase wrap, the one-hot step shifts from bit k to bit k+1.
  - From bit NSTEPS-1 the step wraps to bit 0.
  - One instruction lasts NSTEPS*4 clk cycles (24 at default).
  - run is ignored while in RUN.
- Halt:
  - halt=1 sampled in any RUN cycle sets halt_pend.
  - halt_pend is checked at the last cycle of the instruction (step NSTEPS-1, phase 3).
  - halt sampled in that same cycle also counts.
  - If the halt condition holds at that point: enter HALTED and clear halt_pend, instead of wrapping to step 0.
  - If run and halt are both high in RUN, halt wins.
- State HALTED:
  - Clock outputs and STP_bus are 0; running is 0; instr_cnt holds its value.
  - run=1 re-enters RUN at step 0, phase 0, in the same way as from IDLE.
- instr_cnt:
  - Increments by 1 at every completion of step NSTEPS-1, phase 3, including the instruction that ends in a halt.
  - Wraps modulo 2^CNT_W with no saturation.
- STP_bus is never multi-hot. A bench assertion checks that onehot0 holds at all times.

Optional Feature:
- Macro JCLK_SINGLE_STEP_EN.
- When defined:
  - Adds input step_req (1 bit).
  - Adds input single (1 bit), the mode select.
  - While single=1, after each completed instruction the block enters HALTED (as if halt were pending).
  - In HALTED, a rising edge on step_req acts like run and executes exactly one instruction.
  - A step_req held high does not re-trigger; it must return to 0 first.
- When not defined: these ports are absent and behaviour is exactly as above.

Decomposition:
- Package jclk_pkg holds:
  - the state enum: IDLE, RUN, HALTED;
  - the phase encoding localparams: PH0 to PH3;
  - the per-phase clock output table;
  - the NSTEPS default.
- Sub-module jring_stepper: NSTEPS-bit one-hot ring with inputs clr (forces zero), load0 (loads bit 0) and adv (shift).
- The top level contains the FSM, phase counter, halt latch and counter.

Test Plan:
- Assert reset async mid-cycle in IDLE -> all outputs 0 immediately; instr_cnt=0.
- run=1 for one cycle -> 24-cycle pattern:
  - clk/clkd/clke/clks = 1010, 1111, 0110, 0000 repeating;
  - STP_bus steps 100000 through 000001 over 4 cycles each, then back to 100000;
  - instr_cnt=1 after cycle 24.
- Pulse halt during step 2, phase 1 -> steps 3 to 5 complete; then HALTED with STP_bus=0, running=0, instr_cnt=1; a later run resumes at STP_bus=100000.
- halt high exactly at step 5, phase 3 -> halts at that boundary, instr_cnt incremented.
- Use CNT_W=4 and run 16 instructions -> instr_cnt wraps from 15 to 0.
- Assert reset during step 3, phase 1 -> same-cycle clear to IDLE; next run starts at step 0.
- With JCLK_SINGLE_STEP_EN, single=1 and 3 step_req pulses -> exactly 72 active cycles and instr_cnt=3; holding step_req high runs only one instruction.
